frv_dmem_responder: RTL and testbench

- Data-memory target for the core's dmem request/response interface. It is the responder side of the channel the memory stage's LSU drives.
- Accepts one request at a time from dmem_req/wen/strb/wdata/addr and grants it after a configurable number of wait states.
- Performs the access on an internal word array, then holds a response on dmem_recv/rdata/error until the core acknowledges it.
- Used as the simulation/FPGA data RAM behind the core, and as a stall generator for pipeline verification.

---
 rtl/frv_dmem_responder.sv | 119 +++++++++++
 tb/tb_frv_dmem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/frv_dmem_responder.sv
// Data-memory responder for the core dmem channel: wait-state grant, word array access, held response.
// Optional macro FRV_DMEM_RAND_STALL_EN adds LFSR-driven extra wait states on top of WAIT_CYCLES.
module frv_dmem_responder #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter logic [31:0] BASE_MASK   = 32'hFFFF_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, STALL, RSP} state_t;

  state_t           state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [4:0]       extra, total;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem [MEM_DEPTH];

`ifdef FRV_DMEM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge g_clk) begin
    if (g_reset) lfsr <= 16'hACE1;
    else         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign extra = {2'b00, lfsr[2:0]};
`else
  assign extra = '0;
`endif

  // Total wait states for a request first seen in IDLE; zero means same-cycle grant.
  assign total = 5'(WAIT_CYCLES) + extra;

  assign hit = ((dmem_addr & BASE_MASK) == BASE_ADDR) && (dmem_addr[1:0] == 2'b00);
  assign idx = dmem_addr[IDX_W+1:2];

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dmem_gnt  = 1'b0;
    if (!g_reset) begin
      unique case (state)
        IDLE: begin
          if (dmem_req) begin
            if (total == 5'd0) begin
              dmem_gnt  = 1'b1;
              state_nxt = RSP;
            end else begin
              cnt_nxt   = total - 5'd1;
              state_nxt = STALL;
            end
          end
        end
        STALL: begin
          if (!dmem_req) begin
            state_nxt = IDLE;
          end else if (cnt != 5'd0) begin
            cnt_nxt = cnt - 5'd1;
          end else begin
            dmem_gnt  = 1'b1;
            state_nxt = RSP;
          end
        end
        RSP: begin
          if (dmem_ack) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_recv  <= 1'b0;
      dmem_error <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (dmem_gnt) begin
        dmem_recv  <= 1'b1;
        dmem_error <= !hit;
        dmem_rdata <= (hit && !dmem_wen) ? mem[idx] : '0;
      end else if (state == RSP && dmem_ack) begin
        dmem_recv <= 1'b0;
      end
    end
  end

  // NOTE: the array is deliberately not reset; contents survive g_reset and it can map onto block RAM.
  always_ff @(posedge g_clk) begin
    if (dmem_gnt && dmem_wen && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_strb[i]) mem[idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Directed bench for frv_dmem_responder: one instance with WAIT_CYCLES=0, one with WAIT_CYCLES=3.
module tb_frv_dmem_responder;

  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  logic        a_reset, a_req, a_wen, a_ack, a_gnt, a_recv, a_error;
  logic [3:0]  a_strb;
  logic [31:0] a_wdata, a_addr, a_rdata;
  logic        b_reset, b_req, b_wen, b_ack, b_gnt, b_recv, b_error;
  logic [3:0]  b_strb;
  logic [31:0] b_wdata, b_addr, b_rdata;

  frv_dmem_responder #(.WAIT_CYCLES(0)) u_a (
    .g_clk(g_clk), .g_reset(a_reset), .dmem_req(a_req), .dmem_wen(a_wen),
    .dmem_strb(a_strb), .dmem_wdata(a_wdata), .dmem_addr(a_addr),
    .dmem_gnt(a_gnt), .dmem_recv(a_recv), .dmem_ack(a_ack),
    .dmem_error(a_error), .dmem_rdata(a_rdata)
  );

  frv_dmem_responder #(.WAIT_CYCLES(3)) u_b (
    .g_clk(g_clk), .g_reset(b_reset), .dmem_req(b_req), .dmem_wen(b_wen),
    .dmem_strb(b_strb), .dmem_wdata(b_wdata), .dmem_addr(b_addr),
    .dmem_gnt(b_gnt), .dmem_recv(b_recv), .dmem_ack(b_ack),
    .dmem_error(b_error), .dmem_rdata(b_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic a_step(input logic req, input logic wen, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic ack);
    @(negedge g_clk);
    a_req = req; a_wen = wen; a_strb = strb; a_addr = addr; a_wdata = wdata; a_ack = ack;
    #1;
  endtask

  task automatic b_step(input logic req, input logic wen, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic ack);
    @(negedge g_clk);
    b_req = req; b_wen = wen; b_strb = strb; b_addr = addr; b_wdata = wdata; b_ack = ack;
    #1;
  endtask

  // Zero-wait transaction: grant with the request, one-cycle response acked immediately.
  task automatic a_xact(input string tag, input logic wen, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    a_step(1'b1, wen, strb, addr, wdata, 1'b0);
    check({tag, ".gnt"}, a_gnt, 1);
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check({tag, ".recv"}, a_recv, 1);
    check({tag, ".rdata"}, a_rdata, exp_rd);
    check({tag, ".err"}, a_error, exp_err);
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check({tag, ".recv_drop"}, a_recv, 0);
  endtask

  // Three-wait transaction: grant exactly on the third cycle after the request is first seen.
  task automatic b_xact(input string tag, input logic wen, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    for (int i = 0; i < 3; i++) begin
      b_step(1'b1, wen, strb, addr, wdata, 1'b0);
      check({tag, ".no_gnt"}, b_gnt, 0);
    end
    b_step(1'b1, wen, strb, addr, wdata, 1'b0);
    check({tag, ".gnt"}, b_gnt, 1);
    b_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check({tag, ".recv"}, b_recv, 1);
    check({tag, ".rdata"}, b_rdata, exp_rd);
    check({tag, ".err"}, b_error, exp_err);
    b_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check({tag, ".recv_drop"}, b_recv, 0);
  endtask

  initial begin
    a_reset = 1'b1; a_req = 1'b0; a_wen = 1'b0; a_strb = 4'h0; a_addr = '0; a_wdata = '0; a_ack = 1'b0;
    b_reset = 1'b1; b_req = 1'b0; b_wen = 1'b0; b_strb = 4'h0; b_addr = '0; b_wdata = '0; b_ack = 1'b0;

    // Reset: no grant even with a request present, outputs cleared.
    a_step(1'b1, 1'b0, 4'h0, 32'h0002_0010, 32'h0, 1'b0);
    check("rst.a_gnt", a_gnt, 0);
    @(negedge g_clk);
    a_reset = 1'b0; b_reset = 1'b0; a_req = 1'b0;
    #1;
    check("rst.a_recv", a_recv, 0);
    check("rst.a_err", a_error, 0);
    check("rst.a_rdata", a_rdata, 0);
    check("rst.b_recv", b_recv, 0);
    check("rst.b_gnt", b_gnt, 0);

    // Zero-wait write/read, byte-lane merge.
    a_xact("wr_full", 1'b1, 4'hF, 32'h0002_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    a_xact("rd_full", 1'b0, 4'h0, 32'h0002_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    a_xact("wr_lane1", 1'b1, 4'b0010, 32'h0002_0010, 32'h0000_5500, 32'h0, 1'b0);
    a_xact("rd_lane1", 1'b0, 4'h0, 32'h0002_0010, 32'h0, 32'hDEAD_55EF, 1'b0);

    // Faults: out of window, misaligned, and a write miss that aliases the same index.
    a_xact("rd_miss", 1'b0, 4'h0, 32'h0003_0000, 32'h0, 32'h0, 1'b1);
    a_xact("rd_misal", 1'b0, 4'h0, 32'h0002_0002, 32'h0, 32'h0, 1'b1);
    a_xact("wr_miss", 1'b1, 4'hF, 32'h0003_0010, 32'h1234_5678, 32'h0, 1'b1);
    a_xact("wr_strb0", 1'b1, 4'h0, 32'h0002_0010, 32'hFFFF_FFFF, 32'h0, 1'b0);
    a_xact("rd_after_faults", 1'b0, 4'h0, 32'h0002_0010, 32'h0, 32'hDEAD_55EF, 1'b0);

    // Ack while no response is pending is ignored.
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("stray_ack.recv", a_recv, 0);
    a_xact("rd_after_stray_ack", 1'b0, 4'h0, 32'h0002_0010, 32'h0, 32'hDEAD_55EF, 1'b0);

    // Response held five cycles with a new request pending; ack on the fifth.
    a_step(1'b1, 1'b0, 4'h0, 32'h0002_0010, 32'h0, 1'b0);
    check("hold.gnt", a_gnt, 1);
    for (int k = 0; k < 5; k++) begin
      a_step(1'b1, 1'b0, 4'h0, 32'h0002_0010, 32'h0, (k == 4));
      check("hold.recv", a_recv, 1);
      check("hold.rdata", a_rdata, 32'hDEAD_55EF);
      check("hold.err", a_error, 0);
      check("hold.no_gnt", a_gnt, 0);
    end
    a_step(1'b1, 1'b0, 4'h0, 32'h0002_0010, 32'h0, 1'b0);
    check("hold.recv_drop", a_recv, 0);
    check("hold.regrant", a_gnt, 1);
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("hold.recv2", a_recv, 1);
    check("hold.rdata2", a_rdata, 32'hDEAD_55EF);
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("hold.recv2_drop", a_recv, 0);

    // Reset while in RSP, with a write request present in the reset cycle.
    a_xact("wr_cafe", 1'b1, 4'hF, 32'h0002_0020, 32'hCAFE_F00D, 32'h0, 1'b0);
    a_step(1'b1, 1'b0, 4'h0, 32'h0002_0020, 32'h0, 1'b0);
    check("rsp_rst.gnt", a_gnt, 1);
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("rsp_rst.rdata_pre", a_rdata, 32'hCAFE_F00D);
    @(negedge g_clk);
    a_reset = 1'b1; a_req = 1'b1; a_wen = 1'b1; a_strb = 4'hF; a_addr = 32'h0002_0020; a_wdata = 32'h0;
    #1;
    check("rsp_rst.gnt_in_rst", a_gnt, 0);
    @(negedge g_clk);
    a_reset = 1'b0; a_req = 1'b0; a_wen = 1'b0;
    #1;
    check("rsp_rst.recv", a_recv, 0);
    check("rsp_rst.err", a_error, 0);
    check("rsp_rst.rdata", a_rdata, 0);
    a_xact("rsp_rst.reread", 1'b0, 4'h0, 32'h0002_0020, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Three wait states: exact grant latency.
    b_xact("w3_wr", 1'b1, 4'hF, 32'h0002_0004, 32'h1122_3344, 32'h0, 1'b0);
    b_xact("w3_rd", 1'b0, 4'h0, 32'h0002_0004, 32'h0, 32'h1122_3344, 1'b0);

    // Withdraw after one cycle: no grant, no response, back to IDLE.
    b_step(1'b1, 1'b0, 4'h0, 32'h0002_0004, 32'h0, 1'b0);
    check("w3_wd.gnt0", b_gnt, 0);
    for (int k = 0; k < 3; k++) begin
      b_step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      check("w3_wd.gnt", b_gnt, 0);
      check("w3_wd.recv", b_recv, 0);
    end
    b_xact("w3_wd.after", 1'b0, 4'h0, 32'h0002_0004, 32'h0, 32'h1122_3344, 1'b0);

    // Reset in STALL on the cycle the write would have been granted.
    for (int k = 0; k < 3; k++) begin
      b_step(1'b1, 1'b1, 4'hF, 32'h0002_0004, 32'h0, 1'b0);
      check("w3_rst.no_gnt", b_gnt, 0);
    end
    @(negedge g_clk);
    b_reset = 1'b1;
    #1;
    check("w3_rst.gnt_in_rst", b_gnt, 0);
    @(negedge g_clk);
    b_reset = 1'b0; b_req = 1'b0; b_wen = 1'b0;
    #1;
    check("w3_rst.recv", b_recv, 0);
    check("w3_rst.rdata", b_rdata, 0);
    check("w3_rst.err", b_error, 0);
    b_xact("w3_rst.reread", 1'b0, 4'h0, 32'h0002_0004, 32'h0, 32'h1122_3344, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
